// File: rtl/shift_ctrl_seq_pkg.sv
// Shared widths and FSM encodings for the sequential shift-amount controller.
package shift_ctrl_seq_pkg;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned BW_FL_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/shift_sat_calc.sv
// One channel's relu/residual/quantizer shift amounts, clamped to [0, 2^BW_FL-1].
module shift_sat_calc #(
    parameter int unsigned BW_FL = 5
) (
    input  logic [BW_FL-1:0] i_base,
    input  logic [BW_FL-1:0] i_wgt_fl,
    input  logic [BW_FL-1:0] i_idt_fl,
    input  logic [BW_FL-1:0] i_out_fl,
    input  logic [BW_FL-1:0] i_ftr_fl,
    input  logic             i_align_en,
    output logic [BW_FL-1:0] o_relu_c,
    output logic [BW_FL-1:0] o_resid_c,
    output logic [BW_FL-1:0] o_quant_c,
    output logic             o_sat_c
);

    // Two guard bits cover the full sum/difference range of zero-extended operands.
    localparam int unsigned EW = BW_FL + 2;
    localparam logic signed [EW-1:0] MAXV = EW'((2 ** BW_FL) - 1);

    logic signed [EW-1:0] w_base;
    logic signed [EW-1:0] w_wgt;
    logic signed [EW-1:0] w_idt;
    logic signed [EW-1:0] w_out;
    logic signed [EW-1:0] w_ftr;
    logic signed [EW-1:0] w_relu_raw;
    logic signed [EW-1:0] w_resid_raw;
    logic signed [EW-1:0] w_quant_raw;
    logic [BW_FL:0]       w_relu_cl;
    logic [BW_FL:0]       w_resid_cl;
    logic [BW_FL:0]       w_quant_cl;

    // Returns {clamp_event, clamped_value}.
    function automatic logic [BW_FL:0] clamp(input logic signed [EW-1:0] v);
        logic [BW_FL:0] r;
        if (v[EW-1]) begin
            r = {1'b1, {BW_FL{1'b0}}};
        end else if (v > MAXV) begin
            r = {1'b1, {BW_FL{1'b1}}};
        end else begin
            r = {1'b0, v[BW_FL-1:0]};
        end
        return r;
    endfunction

    assign w_base = EW'(i_base);
    assign w_wgt  = EW'(i_wgt_fl);
    assign w_idt  = EW'(i_idt_fl);
    assign w_out  = EW'(i_out_fl);
    assign w_ftr  = EW'(i_ftr_fl);

    assign w_relu_raw  = i_align_en ? (w_base - w_ftr) : '0;
    assign w_resid_raw = w_base + w_wgt - w_idt;
    assign w_quant_raw = w_base + w_wgt - w_out - EW'(1);

    assign w_relu_cl  = clamp(w_relu_raw);
    assign w_resid_cl = clamp(w_resid_raw);
    assign w_quant_cl = clamp(w_quant_raw);

    assign o_relu_c  = w_relu_cl[BW_FL-1:0];
    assign o_resid_c = w_resid_cl[BW_FL-1:0];
    assign o_quant_c = w_quant_cl[BW_FL-1:0];
    assign o_sat_c   = w_relu_cl[BW_FL] | w_resid_cl[BW_FL] | w_quant_cl[BW_FL];

endmodule

// File: rtl/shift_ctrl_seq.sv
// Sequential shift-amount controller: capture a layer config, scan for max ftr_fl,
// compute clamped per-channel shifts one channel per cycle, hold results until consumed.
module shift_ctrl_seq
    import shift_ctrl_seq_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned BW_FL  = BW_FL_DEF,
    parameter int unsigned CNT_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic                    align_en,
    input  logic [NUM_CH*BW_FL-1:0] ftr_fl,
    input  logic [BW_FL-1:0]        wgt_fl,
    input  logic [NUM_CH*BW_FL-1:0] idt_fl,
    input  logic [NUM_CH*BW_FL-1:0] out_fl,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*BW_FL-1:0] relu_shift,
    output logic [NUM_CH*BW_FL-1:0] residual_shift,
    output logic [NUM_CH*BW_FL-1:0] quant_shift,
    output logic [NUM_CH-1:0]       sat_flag
);

    localparam int unsigned VW = NUM_CH * BW_FL;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_align;
    logic [VW-1:0]      r_ftr;
    logic [VW-1:0]      r_idt;
    logic [VW-1:0]      r_out;
    logic [BW_FL-1:0]   r_wgt;
    logic [BW_FL-1:0]   r_max;
    logic [VW-1:0]      r_relu;
    logic [VW-1:0]      r_resid;
    logic [VW-1:0]      r_quant;
    logic [NUM_CH-1:0]  r_sat;
    logic               r_cfg_ready;
    logic               r_out_valid;

    logic               w_take;
    logic               w_last;
    int unsigned        w_sel_lsb;
    logic [BW_FL-1:0]   w_ftr_sel;
    logic [BW_FL-1:0]   w_idt_sel;
    logic [BW_FL-1:0]   w_out_sel;
    logic [BW_FL-1:0]   w_base;
    logic [BW_FL-1:0]   w_relu_c;
    logic [BW_FL-1:0]   w_resid_c;
    logic [BW_FL-1:0]   w_quant_c;
    logic               w_sat_c;

    assign w_take = (r_state == ST_IDLE) && cfg_valid && r_cfg_ready;
    assign w_last = (r_cnt == CNT_W'(NUM_CH - 1));

    // Channel select: ch0 lives in the MSBs of the flat vectors.
    always_comb begin
        w_sel_lsb = (NUM_CH - 1 - 32'(r_cnt)) * BW_FL;
        w_ftr_sel = r_ftr[w_sel_lsb +: BW_FL];
        w_idt_sel = r_idt[w_sel_lsb +: BW_FL];
        w_out_sel = r_out[w_sel_lsb +: BW_FL];
        w_base    = r_align ? r_max : w_ftr_sel;
    end

    shift_sat_calc #(
        .BW_FL (BW_FL)
    ) u_calc (
        .i_base     (w_base),
        .i_wgt_fl   (r_wgt),
        .i_idt_fl   (w_idt_sel),
        .i_out_fl   (w_out_sel),
        .i_ftr_fl   (w_ftr_sel),
        .i_align_en (r_align),
        .o_relu_c   (w_relu_c),
        .o_resid_c  (w_resid_c),
        .o_quant_c  (w_quant_c),
        .o_sat_c    (w_sat_c)
    );

    // Next-state logic; the scan phase is skipped when not aligning.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_take) w_state_nxt = align_en ? ST_SCAN : ST_CALC;
            ST_SCAN: if (w_last) w_state_nxt = ST_CALC;
            ST_CALC: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Config capture, channel counter and running max of ftr_fl.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_align <= 1'b0;
            r_ftr   <= '0;
            r_idt   <= '0;
            r_out   <= '0;
            r_wgt   <= '0;
            r_max   <= '0;
        end else if (w_take) begin
            r_cnt   <= '0;
            r_align <= align_en;
            r_ftr   <= ftr_fl;
            r_idt   <= idt_fl;
            r_out   <= out_fl;
            r_wgt   <= wgt_fl;
            r_max   <= '0;
        end else if (r_state == ST_SCAN || r_state == ST_CALC) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            // Strict compare keeps the earliest channel on ties.
            if (r_state == ST_SCAN && w_ftr_sel > r_max) begin
                r_max <= w_ftr_sel;
            end
        end
    end

    // Result registers: written only during CALC; sat flags cleared on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_relu  <= '0;
            r_resid <= '0;
            r_quant <= '0;
            r_sat   <= '0;
        end else if (w_take) begin
            r_sat <= '0;
        end else if (r_state == ST_CALC) begin
            r_relu [w_sel_lsb +: BW_FL] <= w_relu_c;
            r_resid[w_sel_lsb +: BW_FL] <= w_resid_c;
            r_quant[w_sel_lsb +: BW_FL] <= w_quant_c;
            r_sat[r_cnt]                <= w_sat_c;
        end
    end

    // Registered handshake outputs, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_ready <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_cfg_ready <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    assign cfg_ready      = r_cfg_ready;
    assign out_valid      = r_out_valid;
    assign relu_shift     = r_relu;
    assign residual_shift = r_resid;
    assign quant_shift    = r_quant;
    assign sat_flag       = r_sat;

endmodule

// File: tb/tb_shift_ctrl_seq.sv
// Randomized self-checking bench for shift_ctrl_seq with an arithmetic reference model.
module tb_shift_ctrl_seq;

    localparam int N    = 4;
    localparam int BW   = 5;
    localparam int VW   = N * BW;
    localparam int MAXV = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          align_en = 1'b0;
    logic [VW-1:0] ftr_fl = '0;
    logic [BW-1:0] wgt_fl = '0;
    logic [VW-1:0] idt_fl = '0;
    logic [VW-1:0] out_fl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] relu_shift;
    logic [VW-1:0] residual_shift;
    logic [VW-1:0] quant_shift;
    logic [N-1:0]  sat_flag;

    always #5 clk = ~clk;

    shift_ctrl_seq #(.NUM_CH(N), .BW_FL(BW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .align_en       (align_en),
        .ftr_fl         (ftr_fl),
        .wgt_fl         (wgt_fl),
        .idt_fl         (idt_fl),
        .out_fl         (out_fl),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .relu_shift     (relu_shift),
        .residual_shift (residual_shift),
        .quant_shift    (quant_shift),
        .sat_flag       (sat_flag)
    );

    int n_vec = 0;
    int n_err = 0;

    // Current transaction as plain integers, channel index 0..N-1.
    int cf_ftr[N];
    int cf_idt[N];
    int cf_out[N];
    int cf_wgt;
    bit cf_align;

    logic [VW-1:0] exp_relu;
    logic [VW-1:0] exp_resid;
    logic [VW-1:0] exp_quant;
    logic [N-1:0]  exp_sat;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int clip(input int v);
        return (v < 0) ? 0 : ((v > MAXV) ? MAXV : v);
    endfunction

    // Reference: expected shifts straight from the arithmetic rules.
    task automatic run_model();
        int mx;
        int b;
        int r;
        int s;
        int q;
        mx = 0;
        for (int i = 0; i < N; i++) if (cf_ftr[i] > mx) mx = cf_ftr[i];
        exp_sat = '0;
        for (int i = 0; i < N; i++) begin
            b = cf_align ? mx : cf_ftr[i];
            r = cf_align ? b - cf_ftr[i] : 0;
            s = b + cf_wgt - cf_idt[i];
            q = b + cf_wgt - cf_out[i] - 1;
            exp_sat[i] = (clip(r) != r) || (clip(s) != s) || (clip(q) != q);
            exp_relu [(N-1-i)*BW +: BW] = BW'(clip(r));
            exp_resid[(N-1-i)*BW +: BW] = BW'(clip(s));
            exp_quant[(N-1-i)*BW +: BW] = BW'(clip(q));
        end
    endtask

    task automatic drive_cfg();
        align_en = cf_align;
        wgt_fl   = BW'(cf_wgt);
        for (int i = 0; i < N; i++) begin
            ftr_fl[(N-1-i)*BW +: BW] = BW'(cf_ftr[i]);
            idt_fl[(N-1-i)*BW +: BW] = BW'(cf_idt[i]);
            out_fl[(N-1-i)*BW +: BW] = BW'(cf_out[i]);
        end
        cfg_valid = 1'b1;
    endtask

    task automatic scramble_inputs();
        align_en = 1'($urandom);
        wgt_fl   = BW'($urandom);
        ftr_fl   = VW'($urandom);
        idt_fl   = VW'($urandom);
        out_fl   = VW'($urandom);
    endtask

    task automatic set_cfg(input bit al, input int f0, input int f1, input int f2, input int f3,
                           input int w, input int id, input int o0, input int o123);
        cf_align = al;
        cf_ftr[0] = f0; cf_ftr[1] = f1; cf_ftr[2] = f2; cf_ftr[3] = f3;
        cf_wgt = w;
        for (int i = 0; i < N; i++) begin
            cf_idt[i] = id;
            cf_out[i] = (i == 0) ? o0 : o123;
        end
    endtask

    // Wait for cfg_ready with a bound; returns 1 when the handshake edge is next.
    task automatic wait_ready(output bit ok);
        int k;
        k = 0;
        while (!cfg_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        ok = cfg_ready;
        if (!ok) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    endtask

    // Full transaction: handshake, latency, hold in DONE, consume.
    task automatic do_txn(input int hold, input bit spam);
        bit ok;
        int cyc;
        @(negedge clk);
        drive_cfg();
        wait_ready(ok);
        if (!ok) begin
            cfg_valid = 1'b0;
            return;
        end
        run_model();
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        scramble_inputs();
        out_ready = 1'($urandom);
        // The handshake cycle is cycle 0.
        cyc = 1;
        while (cyc <= 60) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), cf_align ? 32'(2*N+1) : 32'(N+1));
        if (!out_valid) begin
            out_ready = 1'b0;
            return;
        end
        out_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            if (spam) begin
                cfg_valid = 1'b1;
                scramble_inputs();
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_after_consume", 32'(out_valid), 32'd0);
        check("ready_after_consume", 32'(cfg_ready), 32'd1);
    endtask

    // Compare process: whenever results are presented they must match the model.
    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid) begin
            check("relu_shift",     32'(relu_shift),     32'(exp_relu));
            check("residual_shift", 32'(residual_shift), 32'(exp_resid));
            check("quant_shift",    32'(quant_shift),    32'(exp_quant));
            check("sat_flag",       32'(sat_flag),       32'(exp_sat));
            check("cfg_ready_busy", 32'(cfg_ready),      32'd0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
        check({tag, "_relu"},  32'(relu_shift), 32'd0);
        check({tag, "_resid"}, 32'(residual_shift), 32'd0);
        check({tag, "_quant"}, 32'(quant_shift), 32'd0);
        check({tag, "_sat"},   32'(sat_flag), 32'd0);
    endtask

    initial begin
        bit ok;
        logic [VW-1:0] lit;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        mon_en = 1'b1;

        // Aligned: max ftr is 5.
        set_cfg(1'b1, 3, 5, 5, 2, 4, 6, 4, 4);
        do_txn(2, 1'b0);
        lit = {5'd2, 5'd0, 5'd0, 5'd3};
        check("t1_model_relu", 32'(exp_relu), 32'(lit));
        check("t1_dut_relu",   32'(relu_shift), 32'(lit));
        lit = {5'd3, 5'd3, 5'd3, 5'd3};
        check("t1_dut_resid",  32'(residual_shift), 32'(lit));
        lit = {5'd4, 5'd4, 5'd4, 5'd4};
        check("t1_dut_quant",  32'(quant_shift), 32'(lit));

        // Per-channel base.
        set_cfg(1'b0, 3, 5, 5, 2, 4, 6, 4, 4);
        do_txn(0, 1'b0);
        check("t2_dut_relu", 32'(relu_shift), 32'd0);
        lit = {5'd1, 5'd3, 5'd3, 5'd0};
        check("t2_dut_resid", 32'(residual_shift), 32'(lit));
        lit = {5'd2, 5'd4, 5'd4, 5'd1};
        check("t2_model_quant", 32'(exp_quant), 32'(lit));
        check("t2_dut_quant", 32'(quant_shift), 32'(lit));

        // Underflow on ch0 only; wgt=1 keeps channels 1-3 exactly at zero without clamping.
        set_cfg(1'b1, 0, 0, 0, 0, 1, 0, 3, 0);
        do_txn(1, 1'b0);
        check("t3_dut_quant", 32'(quant_shift), 32'd0);
        check("t3_dut_sat",   32'(sat_flag), 32'b0001);

        // Overflow on every channel.
        set_cfg(1'b1, 31, 31, 31, 31, 31, 0, 0, 0);
        do_txn(0, 1'b0);
        lit = {4{5'd31}};
        check("t4_dut_resid", 32'(residual_shift), 32'(lit));
        check("t4_dut_quant", 32'(quant_shift), 32'(lit));
        check("t4_model_sat", 32'(exp_sat), 32'b1111);
        check("t4_dut_sat",   32'(sat_flag), 32'b1111);

        // Backpressure with new configs offered while results are held.
        set_cfg(1'b1, 3, 5, 5, 2, 4, 6, 4, 4);
        do_txn(5, 1'b1);
        check("t5_dut_sat_cleared", 32'(sat_flag), 32'd0);

        // Asynchronous reset in the middle of SCAN.
        set_cfg(1'b1, 9, 1, 17, 4, 7, 2, 5, 3);
        @(negedge clk);
        drive_cfg();
        wait_ready(ok);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        set_cfg(1'b1, 3, 5, 5, 2, 4, 6, 4, 4);
        do_txn(1, 1'b0);
        lit = {5'd2, 5'd0, 5'd0, 5'd3};
        check("t6_dut_relu", 32'(relu_shift), 32'(lit));

        // Randomized configurations.
        for (int t = 0; t < 40; t++) begin
            cf_align = 1'($urandom);
            cf_wgt   = int'($urandom_range(0, MAXV));
            for (int i = 0; i < N; i++) begin
                cf_ftr[i] = int'($urandom_range(0, MAXV));
                cf_idt[i] = int'($urandom_range(0, MAXV));
                cf_out[i] = int'($urandom_range(0, MAXV));
            end
            do_txn(int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
